sync_fifo_wr_arb: RTL and testbench
===================================

Name: sync_fifo_wr_arb

Overview:
- Round-robin, packet-locked arbiter that shares the write port of one sync_fifo among 2^ID_WIDTH requesters.
- Each requester presents valid/data/last; once granted, a requester keeps the FIFO write port until it transfers a beat with last=1.
- An idle-timeout counter releases a stalled grant and flags an error.
- Sits between requesters and the write side of sync_fifo; its outputs connect directly to wr_en_i/wdata_i, and the FIFO's wfull_o returns to it.

Parameters:
- DATA_WIDTH, 16, width of one data beat (matches the FIFO).
- ID_WIDTH, 2, requester index width; NUM_REQ = 2^ID_WIDTH.
- TIMEOUT, 255, number of consecutive cycles a granted requester may hold valid low mid-packet before forced release; 0 disables the timeout; max 2^16-1.

Ports:
- clk_i  input  1  clock
- resetn_i  input  1  reset, asynchronous, active-low
- req_valid_i  input  NUM_REQ  per-requester beat valid
- req_data_i  input  NUM_REQ*DATA_WIDTH  per-requester beat; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  input  NUM_REQ  last beat of packet
- req_ready_o  output  NUM_REQ  beat accepted when valid&ready
- fifo_wr_en_o  output  1  to FIFO wr_en_i
- fifo_wdata_o  output  DATA_WIDTH  to FIFO wdata_i
- fifo_wfull_i  input  1  from FIFO wfull_o
- grant_o  output  NUM_REQ  one-hot current owner; all-zero when idle
- busy_o  output  1  arbiter in LOCKED state
- err_timeout_o  output  1  single-cycle pulse on forced release
- err_id_o  output  ID_WIDTH  index of the last requester released by timeout; holds until the next timeout

Behaviour:
- Reset values: state=IDLE; grant_o=0; busy_o=0; req_ready_o=0; fifo_wr_en_o=0; fifo_wdata_o=0; err_timeout_o=0; err_id_o=0; last_id=NUM_REQ-1; idle counter=0.
- The state machine has two states, IDLE and LOCKED.
- IDLE:
  - If any req_valid_i is high, select the first valid index searching upward from last_id+1 (mod NUM_REQ).
  - Register it as gnt_id and go to LOCKED next cycle.
  - No transfer occurs in IDLE, so the arbitration bubble is 1 cycle per packet.
- LOCKED:
  - grant_o = onehot(gnt_id).
  - req_ready_o[gnt_id] = !fifo_wfull_i; all other ready bits are 0.
  - fifo_wr_en_o = req_valid_i[gnt_id] & !fifo_wfull_i (combinational).
  - fifo_wdata_o = slice gnt_id of req_data_i (combinational mux; passes through while LOCKED).
  - A transfer with req_last_i[gnt_id]=1 sets last_id=gnt_id and returns to IDLE next cycle.
- Throughput: 1 beat/cycle while LOCKED, the FIFO is not full, and valid is high.
- Full: with fifo_wfull_i=1, no beat is accepted, fifo_wr_en_o=0, and the grant is held. Full cycles do not advance the timeout counter.
- Timeout:
  - In LOCKED with fifo_wfull_i=0 and req_valid_i[gnt_id]=0, the idle counter increments; it clears on any transfer and on entering LOCKED.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): pulse err_timeout_o for 1 cycle, set err_id_o=gnt_id, set last_id=gnt_id, return to IDLE.
  - The partial packet already in the FIFO is not retracted.
- Wrap-around: the round-robin search wraps from NUM_REQ-1 to 0; the idle counter saturates and never wraps.
- Simultaneous events: a last-beat transfer and a timeout cannot coincide, because a transfer clears the counter; the transfer wins.
- A requester deasserting valid mid-packet is legal; the grant is held.
- Reset mid-packet: the arbiter returns immediately to the reset values above; no beat is written after resetn_i falls.
- NUM_REQ=1 (ID_WIDTH=0) is not supported; ID_WIDTH ≥ 1.

Optional Feature:
- Macro: SYNC_FIFO_WR_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority in IDLE — if req_valid_i[0]=1 it is always selected, otherwise normal round-robin applies. A packet in progress is never preempted.
- Undefined: pure round-robin for all requesters.

Test Plan:
- Reset, then req_valid_i=4'b0010 with a 3-beat packet (data 0x11,0x22,0x33, last on 0x33) → grant_o=4'b0010 one cycle after valid; fifo_wr_en_o high for 3 consecutive cycles with wdata 0x11,0x22,0x33; grant_o=0 the cycle after; busy_o mirrors.
- All 4 requesters continuously valid with 1-beat packets → grant order 0,1,2,3,0; each write is separated by one idle cycle.
- Requester 2 locked, fifo_wfull_i=1 for 5 cycles mid-packet → req_ready_o=0 and fifo_wr_en_o=0 for those 5 cycles; no timeout; transfer resumes with the next beat, no data lost or duplicated.
- TIMEOUT=8: requester 3 sends 1 beat without last, then drops valid → err_timeout_o pulses exactly 8 cycles after the last transfer; err_id_o=3; requester 0 (valid) is granted next, per round-robin.
- resetn_i asserted while requester 1 is mid-packet → all outputs return to reset values asynchronously; after release, requester 0 is selected first when all are valid.
- With SYNC_FIFO_WR_ARB_PRIO0_EN defined, requesters 0 and 2 both valid after requester 0's packet ends → requester 0 is regranted; undefined → requester 2 is granted.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin, packet-locked arbiter sharing one sync_fifo write port.
// Optional build macro SYNC_FIFO_WR_ARB_PRIO0_EN gives requester 0 strict priority when idle.
module sync_fifo_wr_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH = 2,
    parameter int TIMEOUT = 255,
    localparam int NUM_REQ = 1 << ID_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    input  logic                          fifo_wfull_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          err_timeout_o,
    output logic [ID_WIDTH-1:0]           err_id_o
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [ID_WIDTH-1:0] gnt_id, last_id, sel_id, idx;
    logic [15:0] idle_cnt;
    logic sel_vld, locked, xfer, idle, fire, done;
    assign locked = state == LOCKED;
    assign xfer = locked & req_valid_i[gnt_id] & ~fifo_wfull_i;
    assign idle = locked & ~req_valid_i[gnt_id] & ~fifo_wfull_i;
    assign fire = (TIMEOUT != 0) && idle && (idle_cnt == 16'(TIMEOUT - 1));
    assign done = (xfer & req_last_i[gnt_id]) | fire;
    // Pick the first valid requester after last_id, wrapping; optional strict priority for requester 0
    always_comb begin
        sel_id = '0;
        sel_vld = 1'b0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last_id + ID_WIDTH'(i);
            if (req_valid_i[idx]) begin
                sel_id = idx;
                sel_vld = 1'b1;
            end
        end
`ifdef SYNC_FIFO_WR_ARB_PRIO0_EN
        if (req_valid_i[0]) begin
            sel_id = '0;
            sel_vld = 1'b1;
        end
`else
`endif
    end
    // Next state: lock on any request, release on last beat or timeout
    always_comb begin
        state_nxt = state;
        if (!locked) state_nxt = sel_vld ? LOCKED : IDLE;
        else if (done) state_nxt = IDLE;
    end
    // Write-port steering to the granted requester while locked
    always_comb begin
        grant_o = '0;
        req_ready_o = '0;
        fifo_wdata_o = '0;
        fifo_wr_en_o = xfer;
        busy_o = locked;
        if (locked) begin
            grant_o[gnt_id] = 1'b1;
            req_ready_o[gnt_id] = ~fifo_wfull_i;
            fifo_wdata_o = req_data_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    // State, grant bookkeeping, saturating idle counter and timeout flags
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= IDLE;
            gnt_id <= '0;
            last_id <= '1;
            idle_cnt <= '0;
            err_timeout_o <= 1'b0;
            err_id_o <= '0;
        end else begin
            state <= state_nxt;
            err_timeout_o <= fire;
            if (!locked && sel_vld) gnt_id <= sel_id;
            if (done) last_id <= gnt_id;
            if (fire) err_id_o <= gnt_id;
            idle_cnt <= (!locked || xfer) ? '0 : (idle && idle_cnt != '1) ? idle_cnt + 16'd1 : idle_cnt;
        end
    end
endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// tb_sync_fifo_wr_arb: directed bench for sync_fifo_wr_arb (TIMEOUT=8, four requesters).
module tb_sync_fifo_wr_arb;
    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic [3:0]  req_valid_i = '0;
    logic [63:0] req_data_i = '0;
    logic [3:0]  req_last_i = '0;
    logic [3:0]  req_ready_o;
    logic        fifo_wr_en_o;
    logic [15:0] fifo_wdata_o;
    logic        fifo_wfull_i = 1'b0;
    logic [3:0]  grant_o;
    logic        busy_o;
    logic        err_timeout_o;
    logic [1:0]  err_id_o;
    int n_cmp = 0;
    int n_err = 0;
`ifdef SYNC_FIFO_WR_ARB_PRIO0_EN
    localparam int PRIO_WIN = 0;
`else
    localparam int PRIO_WIN = 2;
`endif

    sync_fifo_wr_arb #(.DATA_WIDTH(16), .ID_WIDTH(2), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_wdata_o(fifo_wdata_o), .fifo_wfull_i(fifo_wfull_i), .grant_o(grant_o),
        .busy_o(busy_o), .err_timeout_o(err_timeout_o), .err_id_o(err_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [3:0] g, input logic [3:0] r, input logic we, input logic [15:0] wd);
        chk({tag, ".grant"}, 32'(grant_o), 32'(g));
        chk({tag, ".ready"}, 32'(req_ready_o), 32'(r));
        chk({tag, ".wr_en"}, 32'(fifo_wr_en_o), 32'(we));
        chk({tag, ".wdata"}, 32'(fifo_wdata_o), 32'(wd));
        chk({tag, ".busy"}, 32'(busy_o), 32'(|g));
    endtask

    task automatic nxt;
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #1;
        chk_o("rst", 4'h0, 4'h0, 1'b0, 16'h0);
        chk("rst.err", 32'(err_timeout_o), 32'h0);
        chk("rst.err_id", 32'(err_id_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #2 resetn_i = 1'b1;
        // single 3-beat packet from requester 1
        req_valid_i = 4'b0010; req_data_i[16 +: 16] = 16'h11;
        #1 chk_o("t1_idle", 4'h0, 4'h0, 1'b0, 16'h0);
        nxt; #1 chk_o("t1_b1", 4'b0010, 4'b0010, 1'b1, 16'h11);
        nxt; req_data_i[16 +: 16] = 16'h22;
        #1 chk_o("t1_b2", 4'b0010, 4'b0010, 1'b1, 16'h22);
        nxt; req_data_i[16 +: 16] = 16'h33; req_last_i = 4'b0010;
        #1 chk_o("t1_b3", 4'b0010, 4'b0010, 1'b1, 16'h33);
        nxt; req_valid_i = '0; req_last_i = '0;
        #1 chk_o("t1_done", 4'h0, 4'h0, 1'b0, 16'h0);
        // requester 2: valid gap then FIFO full; full cycles must not feed the timeout
        req_valid_i = 4'b0100; req_data_i[32 +: 16] = 16'h41;
        #1 chk_o("t3_idle", 4'h0, 4'h0, 1'b0, 16'h0);
        nxt; #1 chk_o("t3_b1", 4'b0100, 4'b0100, 1'b1, 16'h41);
        nxt; req_valid_i = '0;
        for (int i = 0; i < 6; i++) begin
            #1 chk_o("t3_gap", 4'b0100, 4'b0100, 1'b0, 16'h41);
            chk("t3_gap.err", 32'(err_timeout_o), 32'h0);
            nxt;
        end
        req_valid_i = 4'b0100; req_data_i[32 +: 16] = 16'h42; fifo_wfull_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk_o("t3_full", 4'b0100, 4'b0000, 1'b0, 16'h42);
            chk("t3_full.err", 32'(err_timeout_o), 32'h0);
            nxt;
        end
        fifo_wfull_i = 1'b0;
        #1 chk_o("t3_b2", 4'b0100, 4'b0100, 1'b1, 16'h42);
        chk("t3_b2.err", 32'(err_timeout_o), 32'h0);
        nxt; req_data_i[32 +: 16] = 16'h43; req_last_i = 4'b0100;
        #1 chk_o("t3_b3", 4'b0100, 4'b0100, 1'b1, 16'h43);
        nxt; req_valid_i = '0; req_last_i = '0;
        #1 chk_o("t3_done", 4'h0, 4'h0, 1'b0, 16'h0);
        // requester 3 stalls mid-packet; released after 8 idle cycles
        req_valid_i = 4'b1000; req_data_i[48 +: 16] = 16'h77;
        #1 chk_o("t4_idle", 4'h0, 4'h0, 1'b0, 16'h0);
        nxt; #1 chk_o("t4_b1", 4'b1000, 4'b1000, 1'b1, 16'h77);
        nxt; req_valid_i = 4'b0001; req_data_i[0 +: 16] = 16'h55; req_last_i = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1 chk_o("t4_stall", 4'b1000, 4'b1000, 1'b0, 16'h77);
            chk("t4_stall.err", 32'(err_timeout_o), 32'h0);
            nxt;
        end
        #1 chk("t4_to.err", 32'(err_timeout_o), 32'h1);
        chk("t4_to.err_id", 32'(err_id_o), 32'h3);
        chk_o("t4_to", 4'h0, 4'h0, 1'b0, 16'h0);
        nxt; #1 chk("t4_pulse_end", 32'(err_timeout_o), 32'h0);
        chk_o("t4_r0", 4'b0001, 4'b0001, 1'b1, 16'h55);
        // requesters 0 and 2 compete right after requester 0 finished
        nxt; req_valid_i = 4'b0101; req_last_i = 4'b0101; req_data_i[0 +: 16] = 16'h56; req_data_i[32 +: 16] = 16'h66;
        #1 chk_o("t6_idle", 4'h0, 4'h0, 1'b0, 16'h0);
        chk("t6.err_id_hold", 32'(err_id_o), 32'h3);
        nxt;
        #1 chk_o("t6_win", 4'(1 << PRIO_WIN), 4'(1 << PRIO_WIN), 1'b1, PRIO_WIN == 0 ? 16'h56 : 16'h66);
        nxt; req_valid_i = '0; req_last_i = '0;
        #1 chk_o("t6_done", 4'h0, 4'h0, 1'b0, 16'h0);
        // asynchronous reset while requester 1 is mid-packet
        req_valid_i = 4'b0010; req_data_i[16 +: 16] = 16'h91;
        nxt; #1 chk_o("t5_b1", 4'b0010, 4'b0010, 1'b1, 16'h91);
        #2 resetn_i = 1'b0;
        #1 chk_o("t5_rst", 4'h0, 4'h0, 1'b0, 16'h0);
        chk("t5_rst.err_id", 32'(err_id_o), 32'h0);
        nxt; #1 chk_o("t5_rst_hold", 4'h0, 4'h0, 1'b0, 16'h0);
        resetn_i = 1'b1;
        req_valid_i = 4'b1111; req_last_i = 4'b1111;
        for (int k = 0; k < 4; k++) req_data_i[k*16 +: 16] = 16'(16'hA0 + k);
        #1 chk_o("t2_idle", 4'h0, 4'h0, 1'b0, 16'h0);
        // all requesters valid with 1-beat packets: order 0,1,2,3,0 with a bubble between
        for (int s = 0; s < 5; s++) begin
            nxt; #1 chk_o("t2_gnt", 4'(1 << (s % 4)), 4'(1 << (s % 4)), 1'b1, 16'(16'hA0 + (s % 4)));
            nxt; #1 chk_o("t2_gap", 4'h0, 4'h0, 1'b0, 16'h0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
